fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Holds the PC and issues one-outstanding requests to instruction memory over a req/ack handshake.
- Buffers returned words in a small queue, then presents {instr, pc} to the decoder with valid/ready.
- Accepts redirects (branch/jump) from execute, flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- QUEUE_DEPTH, 2, entries in the instruction queue; legal values 1..8.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, word aligned; bits [1:0] always 0.
- imem_ack  in  1  response valid. Sampled on clk only while imem_req=1; may assert in the same cycle as req (zero-wait).
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- redirect  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  new PC; bits [1:0] ignored (forced to 0).
- instr_valid  out  1  queue head valid toward decoder.
- instr  out  32  queue head instruction.
- instr_pc  out  32  PC of queue head instruction.
- instr_ready  in  1  decoder accepts head when instr_valid && instr_ready.

Behaviour:
- Reset (reset_n=0 at rising edge):
  - fetch_pc=RESET_PC; queue empty; state=RUN.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0.
- States:
  - RUN: normal fetch.
  - DRAIN: a redirect arrived while a request was outstanding; waiting for the stale ack.
- Issue rule (RUN):
  - imem_req=1 iff (queue_count + outstanding) < QUEUE_DEPTH.
  - imem_addr=fetch_pc.
  - Once raised, imem_req and imem_addr stay stable until imem_ack.
- Ack in RUN:
  - Push {imem_rdata, fetch_pc} into the queue.
  - fetch_pc += 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - imem_req may stay high next cycle for the next address if the issue rule allows, giving 1 instr/cycle throughput with zero-wait memory.
- Push and pop in the same cycle: count unchanged. A push into a full queue cannot occur because of the issue rule.
- Output: instr_valid = queue non-empty; instr/instr_pc = head entry. Head is stable while valid && !ready.
- Latency: with an empty queue and a zero-wait ack in cycle N, instr_valid=1 in cycle N+1.
- Redirect (highest priority, evaluated at rising edge):
  - Queue flushed. A head handshake in the same cycle still counts as consumed.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - No request outstanding, or ack arrives in the same cycle: the ack data is discarded; stay in RUN and issue at the new PC next cycle.
  - Request outstanding without ack: enter DRAIN. imem_req and old imem_addr held until ack. Ack data discarded. Then RUN at the new PC; imem_req may be 0 for one cycle.
  - Redirect while in DRAIN: update target PC only; remain in DRAIN.
- instr_valid=0 in the cycle after any redirect.
- No output toggles on X inputs while reset_n=0.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds output perf_fetch_cnt [31:0]: count of completed instr_valid&&instr_ready handshakes.
  - Adds output perf_flush_cnt [31:0]: count of redirect pulses.
  - Both cleared on reset; both wrap at 2^32.
- Undefined: both ports and both counters absent; all other behaviour identical.

Test Plan:
- Reset with RESET_PC=32'h100:
  - During reset: imem_req=0, instr_valid=0.
  - First cycle after reset: imem_req=1, imem_addr=32'h100.
- Zero-wait memory, instr_ready=1 held:
  - Addresses 0x100, 0x104, 0x108 issued on consecutive cycles.
  - instr_pc follows one cycle behind; instr matches the returned words.
- instr_ready=0 with QUEUE_DEPTH=2:
  - After 2 acks, imem_req drops to 0; head stays 0x100.
  - Raising ready pops one per cycle and fetch resumes at 0x108.
- Ack delayed 3 cycles; redirect to 32'h203 asserted during the wait:
  - imem_addr is held at the old value until the ack.
  - Ack data is not presented.
  - Next request uses imem_addr=32'h200; first valid has instr_pc=32'h200.
- Redirect to 32'hFFFF_FFFC:
  - Fetches 0xFFFF_FFFC, then 0x0000_0000.
- reset_n deasserted mid-DRAIN:
  - Next cycle: queue empty, instr_valid=0, imem_addr=RESET_PC.
  - Stale ack afterward is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage sitting directly upstream of the decoder.
//
// Holds the fetch PC and keeps at most one instruction-memory request
// outstanding on a req/ack handshake. Returned words go into a small circular
// queue together with their PC. The queue head is presented to the decoder
// with a valid/ready handshake. A redirect from execute flushes the queue and
// restarts fetch at the new PC. A request that is already in flight is allowed
// to finish (DRAIN state) so that the memory handshake is never broken, and its
// data is then dropped.
//
// Parameters:
//   RESET_PC     PC loaded on reset.
//   QUEUE_DEPTH  instruction-queue entries, 1..8.
//
// Ports:
//   clk, reset_n            clock; synchronous active-low reset
//   imem_req / imem_addr    fetch request and word-aligned address (held until ack)
//   imem_ack / imem_rdata   response strobe (zero-wait allowed) and instruction word
//   redirect / redirect_pc  one-cycle restart pulse and target (bits [1:0] ignored)
//   instr_valid / instr / instr_pc / instr_ready   queue head toward the decoder
//
// Optional build macro FETCH_PERF_EN adds perf_fetch_cnt (decoder handshakes)
// and perf_flush_cnt (redirect pulses). Both are 32-bit and wrap.

module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } stateT;

  // Circular pointer increment that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Registers
  stateT             stateR;
  logic [31:0]       fetchPcR;   // address of the current/next request
  logic [31:0]       drainPcR;   // restart target while waiting for a stale ack
  logic [PTR_W-1:0]  headR;
  logic [PTR_W-1:0]  tailR;
  logic [CNT_W-1:0]  countR;
  logic [31:0]       instrQR [QUEUE_DEPTH];
  logic [31:0]       pcQR    [QUEUE_DEPTH];

  // Next-state signals
  stateT             nextStateS;
  logic [31:0]       nextFetchPcS;
  logic [31:0]       nextDrainPcS;
  logic [PTR_W-1:0]  nextHeadS;
  logic [PTR_W-1:0]  nextTailS;
  logic [CNT_W-1:0]  nextCountS;

  logic [31:0]       targetPcS;
  logic              issueS;
  logic              ackS;
  logic              pushS;
  logic              popS;

  // Masking keeps every redirect_pc bit in use while forcing word alignment.
  assign targetPcS = redirect_pc & 32'hFFFF_FFFC;

  // In RUN the raised request itself is the single outstanding slot, so the
  // issue rule reduces to "queue has room". In DRAIN the stale request must
  // stay up until its ack. Gating with reset_n keeps req low throughout reset,
  // including before the first clock edge.
  assign issueS    = (stateR == DRAIN) ? 1'b1 : (countR < DEPTH_CNT);
  assign imem_req  = reset_n & issueS;
  assign imem_addr = fetchPcR;

  assign ackS  = imem_req & imem_ack;
  assign popS  = (countR != {CNT_W{1'b0}}) & instr_ready;
  // Acked data is only kept in RUN when no redirect overrides it.
  assign pushS = ackS & (stateR == RUN) & ~redirect;

  assign instr_valid = (countR != {CNT_W{1'b0}});
  assign instr       = instrQR[headR];
  assign instr_pc    = pcQR[headR];

  // Fetch FSM: next state, next fetch PC and pending redirect target.
  always_comb begin
    nextStateS   = stateR;
    nextFetchPcS = fetchPcR;
    nextDrainPcS = drainPcR;
    case (stateR)
      RUN: begin
        if (redirect) begin
          if (imem_req && !imem_ack) begin
            // In-flight request cannot be withdrawn: wait for its ack.
            nextStateS   = DRAIN;
            nextDrainPcS = targetPcS;
          end else begin
            nextFetchPcS = targetPcS;
          end
        end else if (ackS) begin
          nextFetchPcS = fetchPcR + 32'd4;
        end else begin
          nextFetchPcS = fetchPcR;
        end
      end
      DRAIN: begin
        if (ackS) begin
          nextStateS   = RUN;
          nextFetchPcS = redirect ? targetPcS : drainPcR;
        end else if (redirect) begin
          nextDrainPcS = targetPcS;
        end else begin
          nextDrainPcS = drainPcR;
        end
      end
      default: begin
        nextStateS   = RUN;
        nextFetchPcS = fetchPcR;
      end
    endcase
  end

  // Queue pointer and occupancy update; a redirect empties the queue.
  always_comb begin
    nextHeadS  = headR;
    nextTailS  = tailR;
    nextCountS = countR;
    if (redirect) begin
      nextHeadS  = {PTR_W{1'b0}};
      nextTailS  = {PTR_W{1'b0}};
      nextCountS = {CNT_W{1'b0}};
    end else begin
      if (popS) begin
        nextHeadS = ptrInc(headR);
      end else begin
        nextHeadS = headR;
      end
      if (pushS) begin
        nextTailS = ptrInc(tailR);
      end else begin
        nextTailS = tailR;
      end
      case ({pushS, popS})
        2'b10:   nextCountS = countR + CNT_W'(1);
        2'b01:   nextCountS = countR - CNT_W'(1);
        default: nextCountS = countR;
      endcase
    end
  end

  // FSM, PC and queue bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stateR   <= RUN;
      fetchPcR <= RESET_PC;
      drainPcR <= RESET_PC;
      headR    <= {PTR_W{1'b0}};
      tailR    <= {PTR_W{1'b0}};
      countR   <= {CNT_W{1'b0}};
    end else begin
      stateR   <= nextStateS;
      fetchPcR <= nextFetchPcS;
      drainPcR <= nextDrainPcS;
      headR    <= nextHeadS;
      tailR    <= nextTailS;
      countR   <= nextCountS;
    end
  end

  // Queue storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        instrQR[i] <= 32'h0000_0000;
        pcQR[i]    <= 32'h0000_0000;
      end
    end else if (pushS) begin
      instrQR[tailR] <= imem_rdata;
      pcQR[tailR]    <= fetchPcR;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perfFetchCntR;
  logic [31:0] perfFlushCntR;

  assign perf_fetch_cnt = perfFetchCntR;
  assign perf_flush_cnt = perfFlushCntR;

  // Performance counters: decoder handshakes and redirect pulses, wrapping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perfFetchCntR <= 32'h0000_0000;
      perfFlushCntR <= 32'h0000_0000;
    end else begin
      if (popS) begin
        perfFetchCntR <= perfFetchCntR + 32'd1;
      end
      if (redirect) begin
        perfFlushCntR <= perfFlushCntR + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (RESET_PC=0x100, QUEUE_DEPTH=2).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int checks;
  int failures;

  fetch_unit #(
    .RESET_PC    (32'h0000_0100),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;

    // ---- reset ----
    tick();
    tick();
    chk("rst_req",     {31'b0, imem_req},    32'h0);
    chk("rst_valid",   {31'b0, instr_valid}, 32'h0);
    chk("rst_instr",   instr,                32'h0);
    chk("rst_instrpc", instr_pc,             32'h0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_req",  {31'b0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr,         32'h0000_0100);

    // ---- zero-wait streaming, ready held high ----
    instr_ready = 1'b1;
    imem_ack    = 1'b1;
    imem_rdata  = 32'hA000_0100;
    tick();
    chk("zw_addr1",  imem_addr,              32'h0000_0104);
    chk("zw_valid1", {31'b0, instr_valid},   32'h1);
    chk("zw_pc1",    instr_pc,               32'h0000_0100);
    chk("zw_instr1", instr,                  32'hA000_0100);
    imem_rdata = 32'hA000_0104;
    tick();
    chk("zw_addr2",  imem_addr, 32'h0000_0108);
    chk("zw_pc2",    instr_pc,  32'h0000_0104);
    chk("zw_instr2", instr,     32'hA000_0104);
    imem_rdata = 32'hA000_0108;
    tick();
    chk("zw_addr3",  imem_addr, 32'h0000_010C);
    chk("zw_pc3",    instr_pc,  32'h0000_0108);
    imem_ack = 1'b0;
    tick();
    chk("zw_empty", {31'b0, instr_valid}, 32'h0);

    // ---- back-pressure: queue fills, req drops ----
    reset_n = 1'b0;
    tick();
    reset_n     = 1'b1;
    instr_ready = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = 32'hA000_0100;
    tick();
    chk("bp_req1",  {31'b0, imem_req}, 32'h1);
    chk("bp_addr1", imem_addr,         32'h0000_0104);
    imem_rdata = 32'hA000_0104;
    tick();
    chk("bp_req_full",  {31'b0, imem_req},    32'h0);
    chk("bp_head_pc",   instr_pc,             32'h0000_0100);
    chk("bp_head_data", instr,                32'hA000_0100);
    chk("bp_valid",     {31'b0, instr_valid}, 32'h1);
    tick();  // ack held high while req is low: must be ignored
    chk("bp_req_hold", {31'b0, imem_req}, 32'h0);
    chk("bp_pc_hold",  instr_pc,          32'h0000_0100);
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    tick();
    chk("bp_pop_pc",  instr_pc,          32'h0000_0104);
    chk("bp_resume",  {31'b0, imem_req}, 32'h1);
    chk("bp_addr108", imem_addr,         32'h0000_0108);
    imem_ack   = 1'b1;
    imem_rdata = 32'hA000_0108;
    tick();
    chk("bp_pc108",    instr_pc,  32'h0000_0108);
    chk("bp_instr108", instr,     32'hA000_0108);
    chk("bp_addr10c",  imem_addr, 32'h0000_010C);

    // ---- delayed ack with redirects during the wait ----
    imem_ack = 1'b0;
    tick();
    chk("dr_wait_addr",  imem_addr,            32'h0000_010C);
    chk("dr_wait_valid", {31'b0, instr_valid}, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    redirect_pc = 32'h0000_0203;  // retarget while draining
    tick();
    redirect = 1'b0;
    chk("dr_hold_req",  {31'b0, imem_req}, 32'h1);
    chk("dr_hold_addr", imem_addr,         32'h0000_010C);
    tick();
    chk("dr_hold_addr2", imem_addr, 32'h0000_010C);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("dr_stale_valid", {31'b0, instr_valid}, 32'h0);
    chk("dr_new_req",     {31'b0, imem_req},    32'h1);
    chk("dr_new_addr",    imem_addr,            32'h0000_0200);
    imem_ack   = 1'b1;
    imem_rdata = 32'hA000_0200;
    tick();
    chk("dr_first_valid", {31'b0, instr_valid}, 32'h1);
    chk("dr_first_pc",    instr_pc,             32'h0000_0200);
    chk("dr_first_instr", instr,                32'hA000_0200);
    chk("dr_next_addr",   imem_addr,            32'h0000_0204);
    imem_ack = 1'b0;
    tick();

    // ---- redirect with same-cycle ack, PC wrap at top of memory ----
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    imem_ack    = 1'b1;
    imem_rdata  = 32'h0000_BAD0;
    tick();
    redirect = 1'b0;
    chk("wr_valid0", {31'b0, instr_valid}, 32'h0);
    chk("wr_addr",   imem_addr,            32'hFFFF_FFFC);
    imem_rdata = 32'h0000_C0FC;
    tick();
    chk("wr_addr0",  imem_addr, 32'h0000_0000);
    chk("wr_pc_top", instr_pc,  32'hFFFF_FFFC);
    chk("wr_instr",  instr,     32'h0000_C0FC);
    imem_rdata = 32'h0000_C000;
    tick();
    chk("wr_pc0",   instr_pc,  32'h0000_0000);
    chk("wr_addr4", imem_addr, 32'h0000_0004);

    // ---- reset in the middle of DRAIN ----
    imem_ack = 1'b0;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0500;
    tick();
    redirect = 1'b0;
    chk("rd_drain_addr", imem_addr, 32'h0000_0004);
    reset_n    = 1'b0;
    imem_ack   = 1'b1;   // stale ack lands while reset is asserted
    imem_rdata = 32'h5757_5757;
    #1;
    chk("rd_req_in_rst", {31'b0, imem_req}, 32'h0);
    tick();
    reset_n  = 1'b1;
    imem_ack = 1'b0;
    #1;
    chk("rd_valid", {31'b0, instr_valid}, 32'h0);
    chk("rd_addr",  imem_addr,            32'h0000_0100);
    chk("rd_req",   {31'b0, imem_req},    32'h1);
    tick();
    chk("rd_valid2", {31'b0, instr_valid}, 32'h0);
    chk("rd_addr2",  imem_addr,            32'h0000_0100);
    imem_ack   = 1'b1;
    imem_rdata = 32'hA000_0100;
    tick();
    chk("rd_fresh_pc",    instr_pc, 32'h0000_0100);
    chk("rd_fresh_instr", instr,    32'hA000_0100);
    imem_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
